// File: rtl/cpu_result_monitor.sv
// Holds a CPU in reset, releases it from boot_pc and captures every change on its
// result bus into a FIFO. Define MONITOR_TIMEOUT_EN to build the idle watchdog.
module cpu_result_monitor #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned RST_HOLD = 5,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [31:0]              boot_pc,
  input  logic [31:0]              cpu_result,
  output logic                     cpu_rst_n,
  output logic [31:0]              pc_init,
  output logic                     busy,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two, at least 2");
  end
  if (RST_HOLD == 0) begin : g_bad_hold
    $error("RST_HOLD must be at least 1");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [HW-1:0]   r_hold;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [DW-1:0]   r_base;
  logic [DW-1:0]   r_pc_init;
  logic [DW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_overflow;
  logic            r_cpu_rst_n;
  logic            r_busy;

  logic            w_busy_nxt;
  logic            w_cpu_rst_n_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_push_ok;
  logic            w_timeout_hit;
  logic [AW-1:0]   w_rd_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [DW-1:0]   w_head_nxt;

  // A change only counts in RUN and is discarded if start clears the FIFO this cycle.
  assign w_push    = (r_state == S_RUN) && !start && (cpu_result != r_base);
  assign w_pop     = r_out_valid && out_ready && !start;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_rd_nxt  = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  assign w_cnt_nxt = start ? '0 : (r_count + CW'(w_push_ok) - CW'(w_pop));

  // Registered head: the new word becomes head when it lands on the next read slot.
  always_comb begin
    w_head_nxt = '0;
    if (w_cnt_nxt != '0) begin
      if (w_push_ok && (r_wr_ptr == w_rd_nxt)) w_head_nxt = cpu_result;
      else                                     w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = S_HOLD;
    end else begin
      case (r_state)
        S_HOLD:  if (r_hold == HW'(RST_HOLD - 1)) w_state_nxt = S_RUN;
        S_RUN:   if (stop || w_timeout_hit) w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_busy_nxt      = 1'b0;
    w_cpu_rst_n_nxt = 1'b0;
    case (w_state_nxt)
      S_HOLD:  w_busy_nxt = 1'b1;
      S_RUN: begin
        w_busy_nxt      = 1'b1;
        w_cpu_rst_n_nxt = 1'b1;
      end
      default: w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_base      <= '0;
      r_pc_init   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_cpu_rst_n <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_cpu_rst_n <= w_cpu_rst_n_nxt;
      r_count     <= w_cnt_nxt;
      r_out_data  <= w_head_nxt;
      r_out_valid <= (w_cnt_nxt != '0);
      if (start || (r_state != S_HOLD)) r_hold <= '0;
      else                              r_hold <= r_hold + HW'(1);
      if (start) begin
        r_pc_init  <= boot_pc;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push_ok)            r_wr_ptr   <= r_wr_ptr + AW'(1);
        if (w_push && !w_push_ok) r_overflow <= 1'b1;
        r_rd_ptr <= w_rd_nxt;
      end
      if ((r_state == S_HOLD) && (w_state_nxt == S_RUN)) r_base <= cpu_result;
      else if (w_push)                                    r_base <= cpu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= cpu_result;
  end

`ifdef MONITOR_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] r_idle;
  logic          r_timeout;

  // Idle count sits at zero outside RUN, so it is already clear on entry to RUN.
  assign w_timeout_hit = (r_state == S_RUN) && !start && !w_push &&
                         (r_idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (start)              r_timeout <= 1'b0;
      else if (w_timeout_hit) r_timeout <= 1'b1;
      if ((r_state != S_RUN) || w_push) r_idle <= '0;
      else                              r_idle <= r_idle + TW'(1);
    end
  end

  assign timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign timeout       = 1'b0;
`endif

  assign cpu_rst_n = r_cpu_rst_n;
  assign pc_init   = r_pc_init;
  assign busy      = r_busy;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: doc/cpu_result_monitor.md
CPU_RESULT_MONITOR -- requirements
Module: cpu_result_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 8, capture FIFO depth in entries, a power of two, at least 2.
REQ-002 SHALL have parameter RST_HOLD, default 5, number of cycles cpu_rst_n is held low before the CPU run starts, at least 1.
REQ-003 SHALL have parameter TIMEOUT, default 1024, idle-cycle limit used only when MONITOR_TIMEOUT_EN is defined.
REQ-004 Port clk  in  1  single clock, all logic rising-edge.
REQ-005 Port rst  in  1  asynchronous, active-high reset; one clock domain only.
REQ-006 Port start  in  1  single-cycle pulse that begins or restarts a CPU run.
REQ-007 Port stop  in  1  single-cycle pulse that ends a run.
REQ-008 Port boot_pc  in  32  start address, sampled on start.
REQ-009 Port cpu_result  in  32  CPU result bus under observation.
REQ-010 Port cpu_rst_n  out  1  active-low CPU reset.
REQ-011 Port pc_init  out  32  CPU initial PC.
REQ-012 Port busy  out  1  high in HOLD and RUN.
REQ-013 Port out_data  out  32  head FIFO entry.
REQ-014 Port out_valid  out  1  FIFO non-empty.
REQ-015 Port out_ready  in  1  consumer accept.
REQ-016 Port count  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 Port overflow  out  1  sticky, set when a capture is dropped.
REQ-018 Port timeout  out  1  sticky watchdog flag.

Function
REQ-019 FSM states SHALL be IDLE, HOLD and RUN; cpu_rst_n SHALL be 0 in IDLE and HOLD, and 1 in RUN.
REQ-020 In any state, start SHALL latch boot_pc into pc_init, clear the FIFO, overflow and timeout, zero the hold counter, and enter HOLD next cycle.
REQ-021 HOLD SHALL last exactly RST_HOLD cycles, then enter RUN; on that transition cpu_result SHALL be loaded into a baseline register without being pushed.
REQ-022 In RUN, each cycle where cpu_result differs from the baseline SHALL push cpu_result and update the baseline; equal values SHALL NOT be pushed.
REQ-023 A value pushed at edge N SHALL be visible on out_data with out_valid=1 after edge N; there is no fall-through path from cpu_result.
REQ-024 A pop SHALL occur on an edge where out_valid and out_ready are both 1.
REQ-025 When the FIFO is full and a push occurs with no pop, the value SHALL be dropped and overflow set.
REQ-026 When the FIFO is full, a push with a simultaneous pop SHALL be accepted, and count SHALL stay at DEPTH.
REQ-027 When the FIFO is empty, a simultaneous push and pop SHALL NOT be possible because out_valid=0; the push SHALL be accepted.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH, and count SHALL equal pushes minus pops.
REQ-029 In RUN, stop without start SHALL enter IDLE next cycle; FIFO contents SHALL be retained and remain poppable.
REQ-030 If start and stop are asserted together, start SHALL win.
REQ-031 In IDLE or HOLD, stop SHALL be ignored.
REQ-032 No pushes SHALL occur outside RUN.

Reset
REQ-033 rst SHALL asynchronously force state IDLE, cpu_rst_n=0, pc_init=0, busy=0, out_valid=0, count=0, out_data=0, overflow=0 and timeout=0.
REQ-034 Asserting rst mid-run SHALL discard FIFO contents and the baseline immediately.
REQ-035 After rst deasserts, the block SHALL remain in IDLE until start.

Configuration
REQ-036 With MONITOR_TIMEOUT_EN defined, an idle counter SHALL clear on each push and on entry to RUN; after TIMEOUT consecutive RUN cycles without a push, the FSM SHALL enter IDLE and set timeout.
REQ-037 Without MONITOR_TIMEOUT_EN, the watchdog logic SHALL be absent and timeout SHALL be tied to 0.

Verification
REQ-038 rst pulse, then start with boot_pc=0x00000040 -> pc_init=0x40, cpu_rst_n low for exactly 5 cycles, busy=1, then RUN.
REQ-039 In RUN, cpu_result sequence 0,0,5,5,9,0 with baseline 0 and out_ready=0 -> FIFO holds 5,9,0, count=3, overflow=0.
REQ-040 Ten distinct cpu_result changes with out_ready=0 and DEPTH=8 -> count=8, overflow=1, out_data equals the first value captured.
REQ-041 FIFO full, out_ready=1 and a new change arriving in the same cycle -> count stays 8, overflow stays 0, order is preserved across pointer wrap.
REQ-042 In RUN, start and stop pulsed in the same cycle -> HOLD, FIFO cleared, cpu_rst_n=0; separately, rst asserted mid-RUN -> all outputs at reset values immediately.
REQ-043 With MONITOR_TIMEOUT_EN defined and TIMEOUT=16, cpu_result held constant in RUN -> IDLE and timeout=1 after 16 cycles; without the macro -> stays in RUN and timeout=0.
